// File: rtl/clint_timer_ctrl.sv
// CLINT timer/software-interrupt controller: mtime, per-hart mtimecmp/msip, bus access.
// Optional: define CLINT_MTIME_LATCH_EN to add a coherent lo-then-hi mtime read shadow.
module clint_timer_ctrl #(
   parameter int unsigned HART_NUM  = 2,
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [15:0]          addr_i,
   input  logic [31:0]          wdata_i,
   output logic                 ack_o,
   output logic [31:0]          rdata_o,
   output logic                 err_o,
   output logic [HART_NUM-1:0]  msip_o,
   output logic [HART_NUM-1:0]  mtip_o
);

   localparam logic [13:0] MTIME_LO_WA = 14'h2FFE;
   localparam logic [13:0] MTIME_HI_WA = 14'h2FFF;
   localparam logic [12:0] MTIMECMP_DA = 13'h0800;

   logic [63:0]          mtime;
   logic [63:0]          mtimecmp [HART_NUM];
   logic [HART_NUM-1:0]  msip;
   logic [DIV_WIDTH-1:0] presc;
   logic                 tick;

   logic [HART_NUM-1:0]  msip_sel;
   logic [HART_NUM-1:0]  cmp_lo_sel;
   logic [HART_NUM-1:0]  cmp_hi_sel;
   logic                 mtime_lo_sel;
   logic                 mtime_hi_sel;
   logic                 hit;
   logic [31:0]          rd_val;
   logic [31:0]          mtime_hi_rd;
   logic                 wr;
   logic                 rd;
   logic                 unused_addr;

   assign unused_addr = ^addr_i[1:0];
   assign wr          = req_i & we_i;
   assign rd          = req_i & ~we_i;

   always_comb begin
      msip_sel     = '0;
      cmp_lo_sel   = '0;
      cmp_hi_sel   = '0;
      rd_val       = '0;
      mtime_lo_sel = (addr_i[15:2] == MTIME_LO_WA);
      mtime_hi_sel = (addr_i[15:2] == MTIME_HI_WA);
      if (mtime_lo_sel) rd_val = mtime[31:0];
      if (mtime_hi_sel) rd_val = mtime_hi_rd;
      for (int unsigned h = 0; h < HART_NUM; h++) begin
         msip_sel[h]   = (addr_i[15:2] == 14'(h));
         cmp_lo_sel[h] = (addr_i[15:3] == MTIMECMP_DA + 13'(h)) & ~addr_i[2];
         cmp_hi_sel[h] = (addr_i[15:3] == MTIMECMP_DA + 13'(h)) & addr_i[2];
         if (msip_sel[h])   rd_val = {31'b0, msip[h]};
         if (cmp_lo_sel[h]) rd_val = mtimecmp[h][31:0];
         if (cmp_hi_sel[h]) rd_val = mtimecmp[h][63:32];
      end
      hit = mtime_lo_sel | mtime_hi_sel | (|msip_sel) | (|cmp_lo_sel) | (|cmp_hi_sel);
   end

`ifdef CLINT_MTIME_LATCH_EN
   logic [31:0] mtime_hi_shadow;

   // Every low-word read snapshots the high word so the following high read is coherent.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                 mtime_hi_shadow <= '0;
      else if (rd && mtime_lo_sel)  mtime_hi_shadow <= mtime[63:32];
   end

   assign mtime_hi_rd = mtime_hi_shadow;
`else
   assign mtime_hi_rd = mtime[63:32];
`endif

   // A divisor lowered below the running count wraps the prescaler without a tick.
   assign tick = (presc == div_i);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)            presc <= '0;
      else if (presc >= div_i) presc <= '0;
      else                     presc <= presc + DIV_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                  mtime         <= '0;
      else if (wr && mtime_lo_sel)   mtime[31:0]   <= wdata_i;
      else if (wr && mtime_hi_sel)   mtime[63:32]  <= wdata_i;
      else if (tick)                 mtime         <= mtime + 64'd1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned h = 0; h < HART_NUM; h++) mtimecmp[h] <= '1;
         msip   <= '0;
         mtip_o <= '0;
      end else begin
         for (int unsigned h = 0; h < HART_NUM; h++) begin
            if (wr && cmp_lo_sel[h]) mtimecmp[h][31:0]  <= wdata_i;
            if (wr && cmp_hi_sel[h]) mtimecmp[h][63:32] <= wdata_i;
            if (wr && msip_sel[h])   msip[h]            <= wdata_i[0];
            mtip_o[h] <= (mtime >= mtimecmp[h]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= '0;
      end else begin
         ack_o   <= req_i;
         err_o   <= req_i & ~hit;
         rdata_o <= (rd && hit) ? rd_val : '0;
      end
   end

   assign msip_o = msip;

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Self-checking bench for clint_timer_ctrl: scoreboarded bus transactions, vector table, timing sequences.
`timescale 1ns/1ps
module tb_clint_timer_ctrl;

   localparam int unsigned HART_NUM  = 2;
   localparam int unsigned DIV_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [DIV_WIDTH-1:0] div;
   logic                 req;
   logic                 we;
   logic [15:0]          addr;
   logic [31:0]          wdata;
   logic                 ack;
   logic [31:0]          rdata;
   logic                 err;
   logic [HART_NUM-1:0]  msip;
   logic [HART_NUM-1:0]  mtip;

   clint_timer_ctrl #(
      .HART_NUM  (HART_NUM),
      .DIV_WIDTH (DIV_WIDTH)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .div_i   (div),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .ack_o   (ack),
      .rdata_o (rdata),
      .err_o   (err),
      .msip_o  (msip),
      .mtip_o  (mtip)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic [15:0] addr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[$];
   int unsigned cyc   = 0;
   int          tests = 0;
   int          fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Response checker: each request expects its ack on the cycle after it was driven.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         tests++;
         if (ack !== 1'b1 || rdata !== e.rdata || err !== e.err || e.due != cyc) begin
            fails++;
            $display("FAIL bus addr=%h: ack=%b rdata=%h err=%b, required ack=1 rdata=%h err=%b",
                     e.addr, ack, rdata, err, e.rdata, e.err);
         end
      end else begin
         tests++;
         if (ack !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL idle: ack=%b rdata=%h, required ack=0 rdata=0", ack, rdata);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      e.due   = cyc + 1;
      e.addr  = a;
      e.rdata = w ? 32'h0 : exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic do_reset(input logic [DIV_WIDTH-1:0] d);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 1'b0;
      we    = 1'b0;
      div   = d;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      div   = '0;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      #1 rst_n = 1'b0;

      // Reset state and free-running mtime at div_i=0
      do_reset(16'd0);
      chk("reset ack", 32'(ack), 32'h0);
      chk("reset mtip", 32'(mtip), 32'h0);
      chk("reset msip", 32'(msip), 32'h0);
      repeat (10) @(negedge clk);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd10, 1'b0);
      bus(1'b0, 16'hBFFC, 32'h0, 32'd0, 1'b0);

      // div_i=3: one increment every 4 cycles
      do_reset(16'd3);
      repeat (40) @(negedge clk);
      for (int i = 0; i < 5; i++)
         bus(1'b0, 16'hBFF8, 32'h0, (i == 4) ? 32'd11 : 32'd10, 1'b0);

      // Divisor lowered below the running count: wrap without tick
      do_reset(16'd3);
      repeat (2) @(negedge clk);
      div = 16'd1;
      @(negedge clk);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd0, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd0, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd1, 1'b0);

      // mtimecmp[1] = 20: mtip rises one cycle after mtime reaches 20, falls after raise
      do_reset(16'd0);
      bus(1'b1, 16'h4008, 32'd20, 32'h0, 1'b0);
      bus(1'b1, 16'h400C, 32'd0, 32'h0, 1'b0);
      repeat (18) @(negedge clk);
      chk("mtip before match", 32'(mtip), 32'h0);
      @(negedge clk);
      chk("mtip at match+1", 32'(mtip), 32'h2);
      bus(1'b1, 16'h400C, 32'd1, 32'h0, 1'b0);
      chk("mtip on cmp-raise ack", 32'(mtip), 32'h2);
      @(negedge clk);
      chk("mtip after cmp raise", 32'(mtip), 32'h0);

      // msip write latency, then register vector table (mtime frozen by a large divisor)
      do_reset(16'hFFFF);
      chk("msip before write", 32'(msip), 32'h0);
      bus(1'b1, 16'h0004, 32'h1, 32'h0, 1'b0);
      chk("msip after write", 32'(msip), 32'h2);

      vecs.push_back('{1'b0, 16'h4000, 32'h0,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{1'b0, 16'h4004, 32'h0,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{1'b0, 16'h4008, 32'h0,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{1'b0, 16'h400C, 32'h0,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{1'b0, 16'hBFF8, 32'h0,        32'h0,         1'b0});
      vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        32'h0,         1'b0});
      vecs.push_back('{1'b0, 16'h0004, 32'h0,        32'h1,         1'b0});
      vecs.push_back('{1'b0, 16'h0000, 32'h0,        32'h0,         1'b0});
      vecs.push_back('{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 16'h0000, 32'h0,        32'h1,         1'b0});
      vecs.push_back('{1'b0, 16'h0008, 32'h0,        32'h0,         1'b1});
      vecs.push_back('{1'b0, 16'h7000, 32'h0,        32'h0,         1'b1});
      vecs.push_back('{1'b1, 16'h4000, 32'h1234_5678, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 16'h4000, 32'h0,        32'h1234_5678, 1'b0});
      vecs.push_back('{1'b0, 16'h4004, 32'h0,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{1'b1, 16'h400C, 32'hCAFE_F00D, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 16'h400C, 32'h0,        32'hCAFE_F00D, 1'b0});
      vecs.push_back('{1'b0, 16'h4010, 32'h0,        32'h0,         1'b1});
      vecs.push_back('{1'b1, 16'h4010, 32'h1,        32'h0,         1'b1});
      vecs.push_back('{1'b1, 16'h000C, 32'h1,        32'h0,         1'b1});
      vecs.push_back('{1'b1, 16'h0000, 32'h0,        32'h0,         1'b0});
      vecs.push_back('{1'b0, 16'h0006, 32'h0,        32'h1,         1'b0});
      vecs.push_back('{1'b0, 16'hBFF4, 32'h0,        32'h0,         1'b1});
      vecs.push_back('{1'b1, 16'hBFFC, 32'h0000_A5A5, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 16'hBFF8, 32'h0,        32'h0,         1'b0});
      vecs.push_back('{1'b0, 16'hBFFC, 32'h0,        32'h0000_A5A5, 1'b0});
      vecs.push_back('{1'b1, 16'h7FFC, 32'h1,        32'h0,         1'b1});
      for (int i = 0; i < vecs.size(); i++)
         bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
      chk("msip after table", 32'(msip), 32'h2);
      chk("mtip after table", 32'(mtip), 32'h0);

      // Low-word carry, write-vs-tick collision, 64-bit wrap
      do_reset(16'd0);
      bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0);
      @(negedge clk);
      bus(1'b0, 16'hBFF8, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 16'hBFFC, 32'h0, 32'h1, 1'b0);
      bus(1'b1, 16'hBFF8, 32'd5, 32'h0, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd5, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'd6, 1'b0);
      bus(1'b0, 16'hBFFC, 32'h0, 32'h1, 1'b0);
      bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 32'h0, 1'b0);
      bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'hFFFF_FFFF, 1'b0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'h0, 1'b0);
      bus(1'b0, 16'hBFFC, 32'h0, 32'h0, 1'b0);

      // lo-then-hi read pair straddling a low-word carry
      do_reset(16'd0);
      bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 32'h0, 1'b0);
      @(negedge clk);
      bus(1'b0, 16'hBFF8, 32'h0, 32'hFFFF_FFFF, 1'b0);
`ifdef CLINT_MTIME_LATCH_EN
      bus(1'b0, 16'hBFFC, 32'h0, 32'h0, 1'b0);
`else
      bus(1'b0, 16'hBFFC, 32'h0, 32'h1, 1'b0);
`endif

      // Reset asserted while an ack is in flight: the ack is cancelled
      req  = 1'b1;
      we   = 1'b0;
      addr = 16'hBFF8;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("ack cancelled by reset", 32'(ack), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("ack after reset release", 32'(ack), 32'h0);
      bus(1'b0, 16'hBFF8, 32'h0, 32'h0, 1'b0);
      chk("msip after mid reset", 32'(msip), 32'h0);
      repeat (4) @(negedge clk);

      chk("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
